// File: rtl/hpi_bus_master.sv
// HPI PIO sequencer for the CY7C67200: timed single/burst read/write and chip-reset pulse.
// Optional per-direction beat counters are built when HPI_TXN_COUNT_EN is defined.
module hpi_bus_master #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 2,
   parameter int LEN_W      = 4,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2,
   parameter int RST_CYC    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   input  logic              chip_rst_req,
   output logic [ADDR_W-1:0] hpi_addr,
   output logic              hpi_cs_n,
   output logic              hpi_r_n,
   output logic              hpi_w_n,
   output logic              hpi_rst_n,
   output logic [DATA_W-1:0] hpi_dout,
   output logic              hpi_doe,
`ifdef HPI_TXN_COUNT_EN
   input  logic              cnt_clr,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
`endif
   input  logic [DATA_W-1:0] hpi_din
);
   // state  | meaning
   // IDLE   | waiting for a command or chip-reset request
   // WAITD  | write beat waiting for wdata_valid
   // SETUP  | CS and address valid, strobes high
   // STROBE | R_N or W_N low
   // HOLD   | strobes high, CS low, before next beat or idle
   // RSTP   | hpi_rst_n held low
   typedef enum logic [2:0] {IDLE, WAITD, SETUP, STROBE, HOLD, RSTP} state_t;

   state_t              state, state_nxt;
   logic [15:0]         tmr, tmr_nxt;
   logic [LEN_W-1:0]    beat, beat_nxt, lat_len, lat_len_nxt;
   logic                lat_write, lat_write_nxt;
   logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt, hpi_addr_nxt;
   logic                idle_seen, idle_seen_nxt;
   logic                cs_n_nxt, r_n_nxt, w_n_nxt, rst_n_nxt, doe_nxt, rd_valid_nxt;
   logic [DATA_W-1:0]   dout_nxt, rd_data_nxt, din_q;

   // idle_seen forces one idle cycle with CS high between consecutive bursts
   assign cmd_ready   = (state == IDLE) && idle_seen && !chip_rst_req;
   assign busy        = (state != IDLE);
   assign wdata_ready = (state == WAITD) && wdata_valid;

   always_comb begin
      state_nxt     = state;
      tmr_nxt       = tmr;
      beat_nxt      = beat;
      lat_len_nxt   = lat_len;
      lat_write_nxt = lat_write;
      lat_addr_nxt  = lat_addr;
      hpi_addr_nxt  = hpi_addr;
      cs_n_nxt      = hpi_cs_n;
      r_n_nxt       = hpi_r_n;
      w_n_nxt       = hpi_w_n;
      rst_n_nxt     = hpi_rst_n;
      doe_nxt       = hpi_doe;
      dout_nxt      = hpi_dout;
      rd_data_nxt   = rd_data;
      rd_valid_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (chip_rst_req) begin
               state_nxt = RSTP;
               rst_n_nxt = 1'b0;
               tmr_nxt   = 16'(RST_CYC - 1);
            end else if (cmd_valid && cmd_ready) begin
               lat_write_nxt = cmd_write;
               lat_addr_nxt  = cmd_addr;
               lat_len_nxt   = cmd_len;
               beat_nxt      = '0;
               if (cmd_write) begin
                  state_nxt = WAITD;
               end else begin
                  state_nxt    = SETUP;
                  cs_n_nxt     = 1'b0;
                  hpi_addr_nxt = cmd_addr;
                  tmr_nxt      = 16'(SETUP_CYC - 1);
               end
            end
         end
         WAITD: begin
            if (wdata_valid) begin
               dout_nxt     = wdata;
               doe_nxt      = 1'b1;
               state_nxt    = SETUP;
               cs_n_nxt     = 1'b0;
               hpi_addr_nxt = lat_addr;
               tmr_nxt      = 16'(SETUP_CYC - 1);
            end
         end
         SETUP: begin
            if (tmr == '0) begin
               state_nxt = STROBE;
               tmr_nxt   = 16'(STROBE_CYC - 1);
               r_n_nxt   = lat_write;
               w_n_nxt   = !lat_write;
            end else begin
               tmr_nxt = tmr - 16'd1;
            end
         end
         STROBE: begin
            if (tmr == '0) begin
               state_nxt = HOLD;
               tmr_nxt   = 16'(HOLD_CYC - 1);
               r_n_nxt   = 1'b1;
               w_n_nxt   = 1'b1;
               if (!lat_write) begin
                  rd_data_nxt  = din_q;
                  rd_valid_nxt = 1'b1;
               end
            end else begin
               tmr_nxt = tmr - 16'd1;
            end
         end
         HOLD: begin
            if (tmr != '0) begin
               tmr_nxt = tmr - 16'd1;
            end else if (beat == lat_len) begin
               // compare before increment so a full 2^LEN_W burst never wraps early
               state_nxt = IDLE;
               cs_n_nxt  = 1'b1;
               doe_nxt   = 1'b0;
            end else begin
               beat_nxt = beat + 1'b1;
               if (lat_write) begin
                  state_nxt = WAITD;
               end else begin
                  state_nxt = SETUP;
                  tmr_nxt   = 16'(SETUP_CYC - 1);
               end
            end
         end
         RSTP: begin
            if (tmr == '0) begin
               state_nxt = IDLE;
               rst_n_nxt = 1'b1;
            end else begin
               tmr_nxt = tmr - 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      idle_seen_nxt = (state == IDLE) && (state_nxt == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tmr       <= '0;
         beat      <= '0;
         lat_len   <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         idle_seen <= 1'b0;
         hpi_addr  <= '0;
         hpi_cs_n  <= 1'b1;
         hpi_r_n   <= 1'b1;
         hpi_w_n   <= 1'b1;
         hpi_rst_n <= 1'b1;
         hpi_doe   <= 1'b0;
         hpi_dout  <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         din_q     <= '0;
      end else begin
         state     <= state_nxt;
         tmr       <= tmr_nxt;
         beat      <= beat_nxt;
         lat_len   <= lat_len_nxt;
         lat_write <= lat_write_nxt;
         lat_addr  <= lat_addr_nxt;
         idle_seen <= idle_seen_nxt;
         hpi_addr  <= hpi_addr_nxt;
         hpi_cs_n  <= cs_n_nxt;
         hpi_r_n   <= r_n_nxt;
         hpi_w_n   <= w_n_nxt;
         hpi_rst_n <= rst_n_nxt;
         hpi_doe   <= doe_nxt;
         hpi_dout  <= dout_nxt;
         rd_data   <= rd_data_nxt;
         rd_valid  <= rd_valid_nxt;
         din_q     <= hpi_din;
      end
   end

`ifdef HPI_TXN_COUNT_EN
   logic beat_done;
   assign beat_done = (state == STROBE) && (tmr == '0);

   // clear wins over a coincident increment
   always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (beat_done) begin
         if (lat_write) wr_count <= wr_count + 16'd1;
         else           rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hpi_bus_master.sv
// Directed self-checking bench for hpi_bus_master; the counter test is built with HPI_TXN_COUNT_EN.
module tb_hpi_bus_master;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [1:0]  cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic        wdata_valid = 1'b0, wdata_ready, rd_valid, busy;
   logic [15:0] wdata = '0, rd_data, hpi_dout, hpi_din;
   logic        chip_rst_req = 1'b0;
   logic [1:0]  hpi_addr;
   logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, hpi_doe;
`ifdef HPI_TXN_COUNT_EN
   logic        cnt_clr = 1'b0;
   logic [15:0] rd_count, wr_count;
`endif

   int checks = 0, errors = 0;

   // pin-level read model: data word is 0xA000 + number of completed read strobes
   int rd_beat = 0;
   assign hpi_din = 16'hA000 + rd_beat[15:0];

   int n_cyc, cs_low, cs_falls, first_cs, last_cs, w_low, first_w, r_low, rst_low, last_rst;
   int wr_pulses, wacc_idx, acc_idx, addr_bad, dout_bad, proto_err = 0;
   logic [1:0]  exp_addr;
   logic [15:0] exp_dout;
   bit          chk_dout;
   logic        prev_cs_n, prev_r_n, prev_w_n, prev_doe;
   logic [15:0] rd_q[$];

   hpi_bus_master dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .chip_rst_req(chip_rst_req),
      .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
      .hpi_rst_n(hpi_rst_n), .hpi_dout(hpi_dout), .hpi_doe(hpi_doe),
`ifdef HPI_TXN_COUNT_EN
      .cnt_clr(cnt_clr), .rd_count(rd_count), .wr_count(wr_count),
`endif
      .hpi_din(hpi_din)
   );

   always #5 clk = ~clk;

   task automatic clear_mon();
      n_cyc = 0; cs_low = 0; cs_falls = 0; first_cs = -1; last_cs = -1;
      w_low = 0; first_w = -1; r_low = 0; rst_low = 0; last_rst = -1;
      wr_pulses = 0; wacc_idx = -1; acc_idx = -1; addr_bad = 0; dout_bad = 0;
      rd_beat = 0; rd_q.delete();
      prev_cs_n = hpi_cs_n; prev_r_n = hpi_r_n; prev_w_n = hpi_w_n; prev_doe = hpi_doe;
   endtask

   // one clock: sample at negedge, retire accepted handshakes just after posedge
   task automatic run_cycle();
      logic acc, wacc;
      @(negedge clk);
      acc  = cmd_valid && cmd_ready;
      wacc = wdata_valid && wdata_ready;
      if (!hpi_cs_n) begin
         cs_low++;
         if (first_cs < 0) first_cs = n_cyc;
         last_cs = n_cyc;
         if (hpi_addr !== exp_addr) addr_bad++;
         if (chk_dout && hpi_dout !== exp_dout) dout_bad++;
      end
      if (prev_cs_n && !hpi_cs_n) cs_falls++;
      if (!hpi_w_n) begin
         w_low++;
         if (first_w < 0) first_w = n_cyc;
      end
      if (!hpi_r_n) r_low++;
      if (!prev_r_n && hpi_r_n) rd_beat++;
      if (!hpi_rst_n) begin
         rst_low++;
         last_rst = n_cyc;
      end
      if (rd_valid) rd_q.push_back(rd_data);
      if (wacc) begin
         wr_pulses++;
         wacc_idx = n_cyc;
      end
      if (acc) acc_idx = n_cyc;
      if ((!hpi_r_n && !hpi_w_n) || ((!hpi_r_n || !hpi_w_n) && hpi_cs_n)) proto_err++;
      if (hpi_doe !== prev_doe && (!hpi_r_n || !hpi_w_n || !prev_r_n || !prev_w_n)) proto_err++;
      prev_cs_n = hpi_cs_n; prev_r_n = hpi_r_n; prev_w_n = hpi_w_n; prev_doe = hpi_doe;
      @(posedge clk);
      #1;
      if (acc) cmd_valid = 1'b0;
      if (wacc) wdata_valid = 1'b0;
      n_cyc++;
   endtask

   task automatic run_txn(input int budget);
      bit seen = 0, done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         run_cycle();
         if (busy) seen = 1;
         else if (seen) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL txn_timeout: busy still %0b after %0d cycles, required return to idle", busy, budget);
      end
   endtask

   task automatic set_cmd(input logic wr, input logic [1:0] a, input logic [3:0] len);
      cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
      exp_addr = a;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({cmd_ready, wdata_ready, rd_valid, busy, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, hpi_doe} !== 9'b000011110) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 000011110",
                  {cmd_ready, wdata_ready, rd_valid, busy, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, hpi_doe});
      end
      checks++;
      if ({rd_data, hpi_dout, hpi_addr} !== 34'd0) begin
         errors++;
         $display("FAIL reset_data: rd_data=%h dout=%h addr=%0d required all zero", rd_data, hpi_dout, hpi_addr);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_idle: cmd_ready=%b required 0", cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_single_write();
      set_cmd(1'b1, 2'd2, 4'd0);
      wdata = 16'h1234; wdata_valid = 1'b1;
      exp_dout = 16'h1234; chk_dout = 1;
      clear_mon();
      run_txn(40);
      chk_dout = 0;
      checks++;
      if (cs_low != 8) begin errors++; $display("FAIL wr_cs_low: got %0d cycles required 8", cs_low); end
      checks++;
      if (w_low != 4) begin errors++; $display("FAIL wr_strobe_len: got %0d cycles required 4", w_low); end
      checks++;
      if (first_w - first_cs != 2) begin
         errors++; $display("FAIL wr_setup: strobe %0d cycles after CS fall, required 2", first_w - first_cs);
      end
      checks++;
      if (dout_bad != 0 || addr_bad != 0) begin
         errors++; $display("FAIL wr_pins: dout_bad=%0d addr_bad=%0d required 0 0", dout_bad, addr_bad);
      end
      checks++;
      if (wr_pulses != 1 || r_low != 0) begin
         errors++; $display("FAIL wr_pulses: wdata_ready=%0d r_low=%0d required 1 0", wr_pulses, r_low);
      end
   endtask

   task automatic test_read_burst();
      set_cmd(1'b0, 2'd0, 4'd3);
      clear_mon();
      run_txn(80);
      checks++;
      if (rd_q.size() != 4) begin
         errors++; $display("FAIL rd_count: got %0d rd_valid pulses required 4", rd_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q[i] !== 16'hA000 + 16'(i)) begin
               errors++; $display("FAIL rd_data%0d: got %h required %h", i, rd_q[i], 16'hA000 + 16'(i));
            end
         end
      end
      checks++;
      if (cs_low != 32 || cs_falls != 1) begin
         errors++; $display("FAIL rd_cs: low=%0d falls=%0d required 32 1", cs_low, cs_falls);
      end
      checks++;
      if (addr_bad != 0 || r_low != 16 || w_low != 0) begin
         errors++; $display("FAIL rd_pins: addr_bad=%0d r_low=%0d w_low=%0d required 0 16 0", addr_bad, r_low, w_low);
      end
   endtask

   task automatic test_write_stall();
      bit seen = 0, done = 0;
      set_cmd(1'b1, 2'd1, 4'd1);
      wdata = 16'h1111; wdata_valid = 1'b1;
      clear_mon();
      for (int i = 0; i < 80 && !done; i++) begin
         run_cycle();
         if (wr_pulses == 1 && n_cyc == wacc_idx + 12) begin
            checks++;
            if ({hpi_cs_n, hpi_w_n, hpi_r_n, busy, wdata_ready} !== 5'b01110) begin
               errors++;
               $display("FAIL stall_state: cs_n,w_n,r_n,busy,wdata_ready=%b required 01110",
                        {hpi_cs_n, hpi_w_n, hpi_r_n, busy, wdata_ready});
            end
         end
         if (wr_pulses == 1 && n_cyc == wacc_idx + 14) begin
            wdata = 16'h2222; wdata_valid = 1'b1;
         end
         if (busy) seen = 1;
         else if (seen) done = 1;
      end
      checks++;
      if (!done) begin errors++; $display("FAIL stall_timeout: busy=%b required 0", busy); end
      checks++;
      if (wr_pulses != 2) begin errors++; $display("FAIL stall_pulses: got %0d required 2", wr_pulses); end
      checks++;
      if (cs_low != 22 || w_low != 8 || cs_falls != 1) begin
         errors++; $display("FAIL stall_timing: cs_low=%0d w_low=%0d falls=%0d required 22 8 1", cs_low, w_low, cs_falls);
      end
   endtask

   task automatic test_chip_reset();
      set_cmd(1'b0, 2'd1, 4'd0);
      chip_rst_req = 1'b1;
      clear_mon();
      run_cycle();
      chip_rst_req = 1'b0;
      run_txn(40);
      run_txn(40);
      checks++;
      if (rst_low != 16) begin errors++; $display("FAIL rst_len: got %0d cycles required 16", rst_low); end
      checks++;
      if (acc_idx != last_rst + 2) begin
         errors++; $display("FAIL rst_accept: accepted at %0d required %0d", acc_idx, last_rst + 2);
      end
      checks++;
      if (rd_q.size() != 1 || first_cs <= last_rst) begin
         errors++; $display("FAIL rst_then_read: reads=%0d first_cs=%0d required 1 after %0d", rd_q.size(), first_cs, last_rst);
      end
   endtask

   task automatic test_back_to_back();
      set_cmd(1'b0, 2'd3, 4'd0);
      clear_mon();
      run_txn(40);
      cmd_valid = 1'b1;
      run_txn(40);
      checks++;
      if (cs_falls != 2 || cs_low != 16) begin
         errors++; $display("FAIL b2b_cs: falls=%0d low=%0d required 2 16", cs_falls, cs_low);
      end
      checks++;
      if (last_cs - first_cs + 1 - cs_low != 2) begin
         errors++; $display("FAIL b2b_gap: got %0d CS-high cycles required 2", last_cs - first_cs + 1 - cs_low);
      end
      checks++;
      if (rd_q.size() != 2 || rd_q[0] !== 16'hA000 || rd_q[1] !== 16'hA001 || addr_bad != 0) begin
         errors++; $display("FAIL b2b_data: reads=%0d addr_bad=%0d required 2 reads A000 A001 addr 3", rd_q.size(), addr_bad);
      end
   endtask

   task automatic test_max_burst();
      set_cmd(1'b0, 2'd0, 4'd15);
      clear_mon();
      run_txn(200);
      checks++;
      if (rd_q.size() != 16 || cs_falls != 1) begin
         errors++; $display("FAIL max_burst: reads=%0d falls=%0d required 16 1", rd_q.size(), cs_falls);
      end else begin
         checks++;
         if (rd_q[15] !== 16'hA00F) begin
            errors++; $display("FAIL max_last: got %h required A00F", rd_q[15]);
         end
      end
   endtask

   task automatic test_reset_mid_strobe();
      bit hit = 0;
      int rv = 0;
      set_cmd(1'b0, 2'd2, 4'd0);
      clear_mon();
      for (int i = 0; i < 30 && !hit; i++) begin
         run_cycle();
         if (!hpi_r_n) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL mid_no_strobe: hpi_r_n=%b required 0 within 30 cycles", hpi_r_n); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({hpi_r_n, hpi_cs_n, busy, rd_valid, hpi_doe} !== 5'b11000) begin
         errors++; $display("FAIL mid_reset: r_n,cs_n,busy,rd_valid,doe=%b required 11000",
                            {hpi_r_n, hpi_cs_n, busy, rd_valid, hpi_doe});
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rd_valid) rv++;
         if (i == 2) reset = 1'b0;
      end
      checks++;
      if (rv != 0) begin errors++; $display("FAIL mid_rd_valid: got %0d pulses required 0", rv); end
   endtask

`ifdef HPI_TXN_COUNT_EN
   task automatic test_counters();
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      set_cmd(1'b0, 2'd0, 4'd15);
      clear_mon();
      run_txn(200);
      set_cmd(1'b1, 2'd0, 4'd0);
      wdata = 16'h0BEE; wdata_valid = 1'b1;
      run_txn(40);
      checks++;
      if (rd_count !== 16'd16) begin errors++; $display("FAIL cnt_rd: got %0d required 16", rd_count); end
      checks++;
      if (wr_count !== 16'd1) begin errors++; $display("FAIL cnt_wr: got %0d required 1", wr_count); end
      @(negedge clk);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      checks++;
      if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
         errors++; $display("FAIL cnt_clr: rd=%0d wr=%0d required 0 0", rd_count, wr_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_read_burst();
      test_write_stall();
      test_chip_reset();
      test_back_to_back();
      test_max_burst();
      test_reset_mid_strobe();
`ifdef HPI_TXN_COUNT_EN
      test_counters();
`endif
      checks++;
      if (proto_err != 0) begin
         errors++; $display("FAIL pin_protocol: got %0d strobe/CS/doe violations required 0", proto_err);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hpi_bus_master.md
Name: hpi_bus_master

Overview:
- Hardware sequencer for the CY7C67200 OTG Host Port Interface (HPI). Replaces firmware bit-banging of the HPI PIO lines.
- Executes single or burst read/write transactions with parameterised setup, strobe and hold timing.
- Issues a timed chip-reset pulse on request.
- Sits between the system-side command interface and the top-level OTG pins.

Parameters:
- DATA_W, 16, HPI data bus width.
- ADDR_W, 2, HPI register address width.
- LEN_W, 4, burst length field width. Max beats = 2^LEN_W.
- SETUP_CYC, 2, cycles with address and CS valid before the strobe (>=1).
- STROBE_CYC, 4, cycles R_N or W_N is held low (>=1).
- HOLD_CYC, 2, cycles after the strobe before the next beat or idle (>=1).
- RST_CYC, 16, cycles hpi_rst_n is held low for a chip-reset request (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  HPI register address, held for the whole burst.
- cmd_len  in  LEN_W  beats minus 1.
- wdata_valid  in  1  write beat data available.
- wdata  in  DATA_W  write beat data.
- wdata_ready  out  1  one-cycle pulse; wdata consumed this cycle.
- rd_valid  out  1  one-cycle pulse per read beat.
- rd_data  out  DATA_W  read beat data, valid with rd_valid.
- busy  out  1  transaction or reset pulse in progress.
- chip_rst_req  in  1  request an HPI chip-reset pulse.
- hpi_addr  out  ADDR_W  to the OTG address pins.
- hpi_cs_n  out  1  chip select.
- hpi_r_n  out  1  read strobe.
- hpi_w_n  out  1  write strobe.
- hpi_rst_n  out  1  chip reset.
- hpi_dout  out  DATA_W  write data driven to the pins.
- hpi_doe  out  1  tristate output enable.
- hpi_din  in  DATA_W  pin data in; registered one stage internally.

Behaviour:
- Reset values: cmd_ready=0, wdata_ready=0, rd_valid=0, rd_data=0, busy=0, hpi_addr=0, hpi_cs_n=1, hpi_r_n=1, hpi_w_n=1, hpi_rst_n=1, hpi_dout=0, hpi_doe=0.
- All pin outputs are registered.
- FSM states: IDLE, WAITD, SETUP, STROBE, HOLD, RSTP.
- IDLE:
  - cmd_ready=1 unless chip_rst_req=1.
  - chip_rst_req has priority over cmd_valid: go to RSTP with hpi_rst_n=0 and a counter of RST_CYC.
  - On accept: latch write, addr, len; beat counter=0; go to WAITD if write, else SETUP.
- WAITD:
  - Stall until wdata_valid=1.
  - Then latch wdata into hpi_dout, pulse wdata_ready, set hpi_doe=1, go to SETUP.
- SETUP:
  - hpi_cs_n=0, hpi_addr=latched address.
  - Lasts SETUP_CYC cycles, then STROBE.
- STROBE:
  - hpi_r_n or hpi_w_n low for exactly STROBE_CYC cycles.
  - Read: the registered hpi_din is captured on the last strobe cycle. rd_valid pulses on the first HOLD cycle.
- HOLD:
  - Strobe high, CS still low. Lasts HOLD_CYC cycles.
  - Then, if beat==len: hpi_cs_n=1, hpi_doe=0, go to IDLE.
  - Otherwise beat+1, go to WAITD (write) or SETUP (read). The address is unchanged; the HPI DATA port auto-increments internally.
- RSTP: hpi_rst_n=0 for RST_CYC cycles, then 1, then IDLE.
- busy=1 in every state except IDLE.
- cmd_ready=0 during the first IDLE cycle after returning, so back-to-back bursts get >=1 idle cycle with CS high.
- Read and write strobes are never low simultaneously. The strobe is never low while hpi_cs_n=1.
- hpi_doe changes only while both strobes are high.
- chip_rst_req outside IDLE is ignored. It is not queued.
- Burst of 2^LEN_W beats (cmd_len all ones): the beat counter must not wrap early. It is LEN_W+1 bits wide or compares before increment.
- Reset asserted mid-burst: all outputs return to reset values on the next edge, with no partial strobe extension.

Optional Feature:
- Macro: HPI_TXN_COUNT_EN.
- Defined: adds outputs rd_count and wr_count, 16 bits each, plus input cnt_clr.
  - Each counter increments once per completed beat, at HOLD entry.
  - Counters wrap at 0xFFFF to 0.
  - cnt_clr=1 zeroes both counters. If cnt_clr coincides with an increment, the counter becomes 0.
  - reset zeroes both counters.
- Undefined: the ports and counters are absent. Core timing is identical.

Test Plan:
- Single write, addr=2, wdata=0x1234, default timing: CS low 8 cycles, hpi_w_n low exactly 4 cycles starting 2 cycles after CS falls, hpi_dout=0x1234 throughout, one wdata_ready pulse.
- Read burst, addr=0, cmd_len=3, model returns 0xA000+beat: 4 rd_valid pulses with 0xA000..0xA003 in order; address stays 0; CS stays low across beats.
- Write burst with cmd_len=1, wdata_valid withheld 5 cycles before beat 2: FSM holds in WAITD with CS low and both strobes high, then completes; exactly 2 wdata_ready pulses.
- chip_rst_req and cmd_valid asserted together in IDLE: hpi_rst_n low exactly 16 cycles, then the command is accepted with cmd_ready=1 afterwards.
- Reset asserted during STROBE of a read: next cycle hpi_r_n=1, hpi_cs_n=1, busy=0, no rd_valid.
- With HPI_TXN_COUNT_EN: read burst cmd_len=15 followed by a 1-beat write gives rd_count=16, wr_count=1; cnt_clr then gives 0 and 0.
